// File: rtl/capture_pkg.sv
// Shared types and defaults for the capture snapshot buffer.
// State encoding is fixed so software-visible debug taps read stable values.
package capture_pkg;

    localparam int unsigned CAP_DEPTH     = 1024;
    localparam int unsigned CAP_ADDR_BITS = 10;
    localparam int unsigned CAP_DATA_BITS = 32;
    localparam int unsigned CAP_DEC_BITS  = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StFill    = 2'd1,
        StRead    = 2'd2,
        StPresent = 2'd3
    } cap_state_e;

    function automatic logic state_busy(input cap_state_e s);
        return s != StIdle;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port, no reset,
// coded so the synthesiser maps it onto block RAM.
module capture_ram
    import capture_pkg::*;
#(
    parameter int unsigned DEPTH     = CAP_DEPTH,
    parameter int unsigned ADDR_BITS = CAP_ADDR_BITS,
    parameter int unsigned DATA_BITS = CAP_DATA_BITS
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [DATA_BITS-1:0] rdata_o
);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [DATA_BITS-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/capture_buffer.sv
// Snapshot buffer: captures DEPTH decimated samples on request, then drains them
// to the CPU one word at a time over a stb/ack handshake.
module capture_buffer
    import capture_pkg::*;
#(
    parameter int unsigned DEPTH     = CAP_DEPTH,
    parameter int unsigned ADDR_BITS = CAP_ADDR_BITS,
    parameter int unsigned DATA_BITS = CAP_DATA_BITS,
    parameter int unsigned DEC_BITS  = CAP_DEC_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] sample_in,
    input  logic                 sample_stb_in,
    input  logic                 start_in,
    input  logic                 abort_in,
    input  logic [DEC_BITS-1:0]  decimation_in,
    output logic [DATA_BITS-1:0] capture_out,
    output logic                 capture_stb_out,
    input  logic                 capture_ack_in,
    output logic                 busy_out,
    output logic [ADDR_BITS:0]   count_out
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

    cap_state_e           state_q, state_d;
    logic [DEC_BITS-1:0]  dec_reload_q, dec_reload_d;
    logic [DEC_BITS-1:0]  dec_cnt_q, dec_cnt_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_BITS:0]   count_q, count_d;

    logic                 ram_we;
    logic                 ram_re;
    logic [DATA_BITS-1:0] ram_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            dec_reload_q <= '0;
            dec_cnt_q    <= '0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            dec_reload_q <= dec_reload_d;
            dec_cnt_q    <= dec_cnt_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dec_reload_d = dec_reload_q;
        dec_cnt_d    = dec_cnt_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        count_d      = count_q;
        ram_we       = 1'b0;
        ram_re       = 1'b0;

        // Abort outranks start and ack; count is kept so software can see how far FILL got.
        if (abort_in) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_in) begin
                        dec_reload_d = decimation_in;
                        dec_cnt_d    = '0;
                        wr_addr_d    = '0;
                        count_d      = '0;
                        state_d      = StFill;
                    end
                end
                StFill: begin
                    if (sample_stb_in) begin
                        if (dec_cnt_q == '0) begin
                            ram_we    = 1'b1;
                            wr_addr_d = wr_addr_q + 1'b1;
                            count_d   = count_q + 1'b1;
                            dec_cnt_d = dec_reload_q;
                            if (wr_addr_q == LAST_ADDR) begin
                                rd_addr_d = '0;
                                state_d   = StRead;
                            end
                        end else begin
                            dec_cnt_d = dec_cnt_q - 1'b1;
                        end
                    end
                end
                StRead: begin
                    ram_re  = 1'b1;
                    state_d = StPresent;
                end
                StPresent: begin
                    if (capture_ack_in) begin
                        rd_addr_d = rd_addr_q + 1'b1;
                        state_d   = (rd_addr_q == LAST_ADDR) ? StIdle : StRead;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    capture_ram #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (wr_addr_q),
        .wdata_i (sample_in),
        .re_i    (ram_re),
        .raddr_i (rd_addr_q),
        .rdata_o (ram_rdata)
    );

    // RAM output is only loaded in READ, so it holds steady for the whole PRESENT phase;
    // gating by state keeps the bus at zero whenever no word is offered, including reset.
    assign capture_stb_out = (state_q == StPresent);
    assign capture_out     = capture_stb_out ? ram_rdata : '0;
    assign busy_out        = state_busy(state_q);
    assign count_out       = count_q;

endmodule
